// File: rtl/apb_pkg.sv
// Shared types and bus widths for the round-robin APB master.
// Imported by the arbiter and the top-level master.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } arb_state_t;

   // Index width for a requester count, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_arb_master_rr_arbiter.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
// Reports the winning index and whether any request was present.
module rr_arbiter
   import apb_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [IDX_W-1:0] i_last,
   output logic [IDX_W-1:0] o_grant,
   output logic             o_grant_valid
);

   logic [IDX_W-1:0] w_idx;
   logic             w_hit;

   // Walk the ring starting one past the last winner; the first hit sticks.
   always_comb begin
      o_grant       = {IDX_W{1'b0}};
      o_grant_valid = 1'b0;
      w_idx         = {IDX_W{1'b0}};
      w_hit         = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx         = IDX_W'((int'(i_last) + k) % NREQ);
         w_hit         = i_req[w_idx] & ~o_grant_valid;
         o_grant       = w_hit ? w_idx : o_grant;
         o_grant_valid = o_grant_valid | w_hit;
      end
   end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by NREQ requesters through a round-robin arbiter.
// Runs one SETUP/ACCESS transfer at a time with an ACCESS-phase timeout.
module apb_arb_master
   import apb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic                       pclk,
   input  logic                       presetn,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ-1:0]            req_write,
   input  logic [NREQ*APB_ADDR_W-1:0] req_addr,
   input  logic [NREQ*APB_DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]            req_ready,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [APB_DATA_W-1:0]      rsp_rdata,
   output logic                       rsp_err,
   output logic                       psel,
   output logic                       penable,
   output logic                       pwrite,
   output logic [APB_ADDR_W-1:0]      paddr,
   output logic [APB_DATA_W-1:0]      pwdata,
   input  logic [APB_DATA_W-1:0]      prdata,
   input  logic                       pready,
   input  logic                       pslverr
);

   localparam int               IDX_W     = idx_width(NREQ);
   localparam logic [NREQ-1:0]  ONE_HOT_0 = {{(NREQ-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NREQ - 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

   arb_state_t              r_state;
   logic [IDX_W-1:0]        r_last;
   logic [IDX_W-1:0]        r_winner;
   logic [CNT_W-1:0]        r_cnt;
   logic [NREQ-1:0]         r_req_ready;
   logic [NREQ-1:0]         r_rsp_valid;
   logic [APB_DATA_W-1:0]   r_rsp_rdata;
   logic                    r_rsp_err;
   logic                    r_psel;
   logic                    r_penable;
   logic                    r_pwrite;
   logic [APB_ADDR_W-1:0]   r_paddr;
   logic [APB_DATA_W-1:0]   r_pwdata;

   logic [IDX_W-1:0]        w_grant;
   logic                    w_grant_valid;
   logic                    w_match;
   logic                    w_sel_write;
   logic [APB_ADDR_W-1:0]   w_sel_addr;
   logic [APB_DATA_W-1:0]   w_sel_wdata;

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .i_req         (req_valid),
      .i_last        (r_last),
      .o_grant       (w_grant),
      .o_grant_valid (w_grant_valid)
   );

   // Mux the winning requester's command fields out of the packed buses.
   always_comb begin
      w_match     = 1'b0;
      w_sel_write = 1'b0;
      w_sel_addr  = {APB_ADDR_W{1'b0}};
      w_sel_wdata = {APB_DATA_W{1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         w_match     = (w_grant == IDX_W'(k));
         w_sel_write = w_match ? req_write[k] : w_sel_write;
         w_sel_addr  = w_match ? req_addr[k*APB_ADDR_W +: APB_ADDR_W] : w_sel_addr;
         w_sel_wdata = w_match ? req_wdata[k*APB_DATA_W +: APB_DATA_W] : w_sel_wdata;
      end
   end

   // Transfer FSM; every output is a register so the bus never glitches.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state     <= ST_IDLE;
         r_last      <= LAST_RST;
         r_winner    <= {IDX_W{1'b0}};
         r_cnt       <= {CNT_W{1'b0}};
         r_req_ready <= {NREQ{1'b0}};
         r_rsp_valid <= {NREQ{1'b0}};
         r_rsp_rdata <= {APB_DATA_W{1'b0}};
         r_rsp_err   <= 1'b0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= {APB_ADDR_W{1'b0}};
         r_pwdata    <= {APB_DATA_W{1'b0}};
      end else begin
         r_req_ready <= {NREQ{1'b0}};
         r_rsp_valid <= {NREQ{1'b0}};
         case (r_state)
            ST_IDLE: begin
               if (w_grant_valid) begin
                  r_winner    <= w_grant;
                  r_pwrite    <= w_sel_write;
                  r_paddr     <= w_sel_addr;
                  r_pwdata    <= w_sel_wdata;
                  r_psel      <= 1'b1;
                  r_penable   <= 1'b0;
                  r_req_ready <= ONE_HOT_0 << w_grant;
                  r_state     <= ST_SETUP;
               end else begin
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_cnt     <= {CNT_W{1'b0}};
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // A pready on the limit cycle still wins over the timeout.
               if (pready) begin
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= ONE_HOT_0 << r_winner;
                  r_rsp_rdata <= r_pwrite ? {APB_DATA_W{1'b0}} : prdata;
                  r_rsp_err   <= pslverr;
                  r_last      <= r_winner;
                  r_state     <= ST_IDLE;
               end else if (r_cnt == CNT_LIMIT) begin
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= ONE_HOT_0 << r_winner;
                  r_rsp_rdata <= {APB_DATA_W{1'b0}};
                  r_rsp_err   <= 1'b1;
                  r_last      <= r_winner;
                  r_state     <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pwrite    = r_pwrite;
   assign paddr     = r_paddr;
   assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: a 32-word APB RAM slave, queued requesters and a
// transaction-level reference model of arbitration order and responses.
module tb_apb_arb_master;
   import apb_pkg::*;

   localparam int          NREQ      = 2;
   localparam int          TIMEOUT   = 16;
   localparam int          MEM_WORDS = 32;
   localparam logic [31:0] ERR_RDATA = 32'hBAD0_0BAD;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int unsigned gap;
   } txn_t;

   logic                 pclk;
   logic                 presetn;
   logic [NREQ-1:0]      req_valid, req_write, req_ready, rsp_valid;
   logic [NREQ*32-1:0]   req_addr, req_wdata;
   logic [31:0]          rsp_rdata, paddr, pwdata, prdata;
   logic                 rsp_err, psel, penable, pwrite, pready, pslverr;

   apb_arb_master #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // APB RAM slave with random wait states; out-of-range addresses error.
   logic [31:0] slv_mem [MEM_WORDS];
   int unsigned slv_wait;
   int unsigned slv_max_wait;
   logic        slv_ready_en;
   logic        slv_in_range;

   assign slv_in_range = (paddr < 32'(MEM_WORDS));
   assign pready  = slv_ready_en && psel && penable && (slv_wait == 0);
   assign pslverr = pready && !slv_in_range;
   assign prdata  = !pready ? 32'h0 : (slv_in_range ? slv_mem[paddr[4:0]] : ERR_RDATA);

   always @(posedge pclk) begin
      if (!presetn) begin
         for (int k = 0; k < MEM_WORDS; k++) slv_mem[k] <= 32'h0;
         slv_wait <= 0;
      end else begin
         if (psel && !penable) slv_wait <= $urandom_range(slv_max_wait, 0);
         else if (psel && penable && slv_wait != 0) slv_wait <= slv_wait - 1;
         if (pready && pwrite && slv_in_range) slv_mem[paddr[4:0]] <= pwdata;
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_proto
      a_hold_valid: assert property (@(posedge pclk) disable iff (!presetn)
         (req_valid[g] && !req_ready[g]) |=> req_valid[g])
         else $error("requester %0d dropped req_valid before req_ready", g);
   end

   // Reference model state
   txn_t        rq [NREQ][$];
   logic [31:0] mdl_mem [MEM_WORDS];
   int          mdl_last;
   bit          infl_vld;
   int          infl_id;
   txn_t        infl;
   bit          acc [NREQ];
   bit          drop_now [NREQ];
   int unsigned gap_cnt [NREQ];
   logic [NREQ-1:0] drv_valid;
   int          acc_cycles, setup_cycles;
   int          grant_log[$];
   int          rsp_id_log[$];
   logic [31:0] rsp_rd_log[$];
   logic        rsp_err_log[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NREQ; i++) begin
         rq[i].delete();
         acc[i] = 1'b0;
         drop_now[i] = 1'b0;
         gap_cnt[i] = 0;
      end
      for (int k = 0; k < MEM_WORDS; k++) mdl_mem[k] = 32'h0;
      mdl_last = NREQ - 1;
      infl_vld = 1'b0;
      drv_valid = '0;
      req_valid = '0;
   endtask

   task automatic clear_logs();
      grant_log.delete();
      rsp_id_log.delete();
      rsp_rd_log.delete();
      rsp_err_log.delete();
   endtask

   task automatic add_txn(input int id, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int unsigned gap);
      txn_t t;
      t.wr = wr; t.addr = a; t.wdata = d; t.gap = gap;
      rq[id].push_back(t);
   endtask

   function automatic bit all_done();
      bit d = !infl_vld;
      for (int i = 0; i < NREQ; i++)
         d = d && (rq[i].size() == 0) && !acc[i] && !drop_now[i];
      return d;
   endfunction

   // One clock: observe the DUT, update the model, then drive requesters.
   task automatic step();
      int          rid, gid, w, a;
      logic        e_err;
      logic [31:0] e_rd;
      bit          in_rng;
      @(posedge pclk);
      #1;
      if (rsp_valid != '0) begin
         rid = -1;
         for (int i = NREQ - 1; i >= 0; i--) if (rsp_valid[i]) rid = i;
         check_eq("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
         check_eq("rsp_has_inflight", 32'(infl_vld), 32'd1);
         if (infl_vld) begin
            a = int'(infl.addr[4:0]);
            in_rng = (infl.addr < 32'(MEM_WORDS));
            if (!slv_ready_en) begin
               e_err = 1'b1;
               e_rd  = 32'h0;
               check_eq("timeout_access_len", 32'(acc_cycles), 32'(TIMEOUT));
            end else begin
               e_err = !in_rng;
               e_rd  = infl.wr ? 32'h0 : (in_rng ? mdl_mem[a] : ERR_RDATA);
               check_eq("access_len_ok",
                        32'(acc_cycles >= 1 && acc_cycles <= int'(slv_max_wait) + 1), 32'd1);
               if (infl.wr && in_rng) mdl_mem[a] = infl.wdata;
            end
            check_eq("rsp_id", 32'(rid), 32'(infl_id));
            check_eq("rsp_rdata", rsp_rdata, e_rd);
            check_eq("rsp_err", 32'(rsp_err), 32'(e_err));
            check_eq("setup_len", 32'(setup_cycles), 32'd1);
            check_eq("idle_gap_psel", 32'({psel, penable}), 32'd0);
            rsp_id_log.push_back(rid);
            rsp_rd_log.push_back(rsp_rdata);
            rsp_err_log.push_back(rsp_err);
            mdl_last = infl_id;
            infl_vld = 1'b0;
         end
      end
      if (req_ready != '0) begin
         w = -1;
         for (int k = 1; k <= NREQ; k++)
            if (w < 0 && req_valid[(mdl_last + k) % NREQ]) w = (mdl_last + k) % NREQ;
         gid = 0;
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
         check_eq("ready_onehot", 32'($countones(req_ready)), 32'd1);
         check_eq("grant_id", 32'(gid), 32'(w));
         check_eq("setup_phase", 32'({psel, penable}), 32'b10);
         check_eq("grant_queue_nonempty", 32'(rq[gid].size() > 0), 32'd1);
         if (rq[gid].size() > 0) begin
            check_eq("paddr", paddr, rq[gid][0].addr);
            check_eq("pwrite", 32'(pwrite), 32'(rq[gid][0].wr));
            check_eq("pwdata", pwdata, rq[gid][0].wdata);
            infl     = rq[gid][0];
            infl_id  = gid;
            infl_vld = 1'b1;
            acc[gid] = 1'b1;
         end
         grant_log.push_back(gid);
         acc_cycles   = 0;
         setup_cycles = 0;
      end
      if (psel && penable) acc_cycles++;
      if (psel && !penable) setup_cycles++;
      for (int i = 0; i < NREQ; i++) begin
         if (drop_now[i]) begin
            drop_now[i] = 1'b0;
            if (rq[i].size() > 0) rq[i].delete(0);
            drv_valid[i] = 1'b0;
            gap_cnt[i] = (rq[i].size() > 0) ? rq[i][0].gap : 0;
         end
         if (acc[i]) begin
            acc[i] = 1'b0;
            drop_now[i] = 1'b1;
         end
         if (!drv_valid[i] && rq[i].size() > 0) begin
            if (gap_cnt[i] == 0) begin
               drv_valid[i] = 1'b1;
               req_write[i] = rq[i][0].wr;
               req_addr[i*32 +: 32]  = rq[i][0].addr;
               req_wdata[i*32 +: 32] = rq[i][0].wdata;
            end else begin
               gap_cnt[i]--;
            end
         end
      end
      req_valid = drv_valid;
   endtask

   task automatic run(input int budget);
      int c;
      for (c = 0; c < budget && !all_done(); c++) step();
      check_eq("run_completes", 32'(all_done()), 32'd1);
      step();
      step();
   endtask

   task automatic do_reset();
      presetn = 1'b0;
      clear_model();
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      presetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      presetn = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      slv_ready_en = 1'b1;
      slv_max_wait = 0;
      clear_model();
      repeat (3) @(posedge pclk);
      #1;
      check_eq("rst_psel_penable", 32'({psel, penable, pwrite}), 32'd0);
      check_eq("rst_ready_valid", 32'({req_ready, rsp_valid}), 32'd0);
      check_eq("rst_rsp", 32'({rsp_err, rsp_rdata == 32'h0}), 32'd1);
      check_eq("rst_paddr", paddr, 32'h0);
      check_eq("rst_pwdata", pwdata, 32'h0);
      @(negedge pclk);
      presetn = 1'b1;

      // Write then read back on requester 0
      clear_logs();
      slv_max_wait = 2;
      add_txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 0);
      add_txn(0, 1'b0, 32'd5, 32'h0, 1);
      run(200);
      check_eq("wr_rd_count", 32'(rsp_rd_log.size()), 32'd2);
      if (rsp_rd_log.size() == 2) begin
         check_eq("wr_rd_data", rsp_rd_log[1], 32'hDEAD_BEEF);
         check_eq("wr_rd_err", 32'({rsp_err_log[0], rsp_err_log[1]}), 32'd0);
      end

      // Contention straight after reset: requester 0 first
      do_reset();
      clear_logs();
      add_txn(0, 1'b1, 32'd1, 32'h11, 0);
      add_txn(1, 1'b1, 32'd2, 32'h22, 0);
      add_txn(0, 1'b0, 32'd1, 32'h0, 0);
      add_txn(1, 1'b0, 32'd2, 32'h0, 0);
      run(200);
      check_eq("cont_grants", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() == 4)
         check_eq("cont_order", 32'({grant_log[0][1:0], grant_log[1][1:0],
                                     grant_log[2][1:0], grant_log[3][1:0]}), 32'b00_01_00_01);
      if (rsp_rd_log.size() == 4) begin
         check_eq("cont_rd1", rsp_rd_log[2], 32'h11);
         check_eq("cont_rd2", rsp_rd_log[3], 32'h22);
      end

      // Fairness with both requesters always valid
      clear_logs();
      for (int n = 0; n < 3; n++) begin
         add_txn(0, 1'b1, 32'(10 + n), $urandom, 0);
         add_txn(1, 1'b1, 32'(20 + n), $urandom, 0);
      end
      run(300);
      check_eq("fair_count", 32'(grant_log.size()), 32'd6);
      for (int k = 0; k < grant_log.size(); k++)
         check_eq("fair_alternate", 32'(grant_log[k]), 32'(k % 2));

      // Slave error on an out-of-range read
      clear_logs();
      add_txn(0, 1'b0, 32'd40, 32'h0, 0);
      run(100);
      check_eq("slverr_count", 32'(rsp_err_log.size()), 32'd1);
      if (rsp_err_log.size() == 1) check_eq("slverr_flag", 32'(rsp_err_log[0]), 32'd1);

      // Randomised mix against the model
      slv_max_wait = 3;
      clear_logs();
      for (int n = 0; n < 40; n++)
         add_txn($urandom_range(NREQ - 1, 0), 1'($urandom_range(1, 0)),
                 32'($urandom_range(MEM_WORDS + 7, 0)), $urandom, $urandom_range(3, 0));
      run(3000);
      check_eq("rand_count", 32'(rsp_id_log.size()), 32'd40);

      // Timeout with pready held low
      clear_logs();
      slv_ready_en = 1'b0;
      add_txn(0, 1'b0, 32'd3, 32'h0, 0);
      run(100);
      check_eq("to_count", 32'(rsp_rd_log.size()), 32'd1);
      if (rsp_rd_log.size() == 1) begin
         check_eq("to_rdata", rsp_rd_log[0], 32'h0);
         check_eq("to_err", 32'(rsp_err_log[0]), 32'd1);
      end
      check_eq("to_idle_psel", 32'(psel), 32'd0);

      // Reset in the middle of ACCESS
      clear_logs();
      add_txn(0, 1'b0, 32'd7, 32'h0, 0);
      for (int c = 0; c < 50 && !(psel && penable); c++) step();
      check_eq("mid_reached_access", 32'(psel && penable), 32'd1);
      step();
      step();
      #2;
      presetn = 1'b0;
      #1;
      check_eq("mid_rst_psel_penable", 32'({psel, penable}), 32'd0);
      check_eq("mid_rst_ready_valid", 32'({req_ready, rsp_valid}), 32'd0);
      clear_model();
      clear_logs();
      slv_ready_en = 1'b1;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      presetn = 1'b1;
      add_txn(1, 1'b1, 32'd9, 32'h99, 0);
      add_txn(0, 1'b1, 32'd8, 32'h88, 0);
      run(200);
      check_eq("post_rst_no_stale_rsp", 32'(rsp_id_log.size()), 32'd2);
      if (grant_log.size() > 0) check_eq("post_rst_first", 32'(grant_log[0]), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
